// File: rtl/opd_pkg.sv
// Shared types and constants for the OPD DAC transmit path.
package opd_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int FRAME_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    LDAC
  } opd_state_e;

  // Converts a two's-complement sample to the DAC frame word by flipping the sign bit.
  function automatic logic [SAMPLE_W-1:0] to_frame_word(input logic [SAMPLE_W-1:0] sample,
                                                        input logic offset_binary);
    return {sample[SAMPLE_W-1] ^ offset_binary, sample[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/opd_spi_shifter.sv
// SPI serializer: one setup half-period with SCLK low, then FRAME_BITS bits,
// each a low half followed by a high half. SDO moves only on SCLK falling.
module opd_spi_shifter
  import opd_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  done,
  output logic                  sclk,
  output logic                  sdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic [FRAME_BITS-1:0] shreg;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  running;
  logic                  setup_half;
  logic                  half_end;

  assign half_end = (div_cnt == '0);
  // Last cycle of the final high half: the frame owner moves on at this edge.
  assign done     = running && half_end && !setup_half && sclk && (bit_cnt == '0);
  assign sdo      = shreg[FRAME_BITS-1];

  // Half-period divider, bit counter and shift register stepping.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      running    <= 1'b0;
      setup_half <= 1'b0;
      sclk       <= 1'b0;
    end else if (start) begin
      shreg      <= word;
      div_cnt    <= DIV_W'(CLK_DIV - 1);
      bit_cnt    <= BIT_W'(FRAME_BITS - 1);
      running    <= 1'b1;
      setup_half <= 1'b1;
      sclk       <= 1'b0;
    end else if (running) begin
      if (!half_end) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end else begin
        div_cnt <= DIV_W'(CLK_DIV - 1);
        if (setup_half) begin
          setup_half <= 1'b0;
        end else if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk  <= 1'b0;
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
          if (bit_cnt == '0) begin
            running <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - BIT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/opd_dac_tx.sv
// OPD DAC transmitter: one SPI write frame per sample followed by an LDAC
// pulse, with a single latest-wins pending slot while a frame is in flight.
//
// state | meaning
// IDLE  | no frame; starts on tick_i or a pending sample
// SETUP | cs_no low, sclk low, first bit on sdi, CLK_DIV cycles
// SHIFT | 24 bits clocked out by the shifter
// GAP   | cs_no high for CS_GAP cycles
// LDAC  | ldac_no low for LDAC_LEN cycles
module opd_dac_tx
  import opd_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int CS_GAP        = 2,
  parameter int LDAC_LEN      = 2,
  parameter int OFFSET_BINARY = 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                tick_i,
  input  logic [SAMPLE_W-1:0] data_i,
  output logic                sclk_o,
  output logic                sdi_o,
  output logic                cs_no,
  output logic                ldac_no,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? ((CLK_DIV > LDAC_LEN) ? CLK_DIV : LDAC_LEN)
                                               : ((CS_GAP > LDAC_LEN) ? CS_GAP : LDAC_LEN);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  opd_state_e          state;
  logic [TMR_W-1:0]    tmr;
  logic                pend_valid;
  logic [SAMPLE_W-1:0] pend_word;
  logic [SAMPLE_W-1:0] tick_word;
  logic [SAMPLE_W-1:0] start_word;
  logic                start;
  logic                sh_done;

  assign tick_word  = to_frame_word(data_i, OFFSET_BINARY != 0);
  // A fresh tick in IDLE beats the pending slot.
  assign start      = (state == IDLE) && (tick_i || pend_valid);
  assign start_word = tick_i ? tick_word : pend_word;

  opd_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .start   (start),
    .word    (start_word),
    .done    (sh_done),
    .sclk    (sclk_o),
    .sdo     (sdi_o)
  );

  // Pending slot: any tick outside IDLE lands here; dropping a valid entry flags overrun.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= tick_i && pend_valid;
      if (state == IDLE) begin
        pend_valid <= 1'b0;
      end else if (tick_i) begin
        pend_valid <= 1'b1;
        pend_word  <= tick_word;
      end
    end
  end

  // Frame sequencing with a shared down-counter for SETUP, GAP and LDAC.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= IDLE;
      tmr     <= '0;
      cs_no   <= 1'b1;
      ldac_no <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SETUP;
            tmr    <= TMR_W'(CLK_DIV - 1);
            cs_no  <= 1'b0;
            busy_o <= 1'b1;
          end
        end
        SETUP: begin
          if (tmr == '0) state <= SHIFT;
          else           tmr   <= tmr - TMR_W'(1);
        end
        SHIFT: begin
          if (sh_done) begin
            state <= GAP;
            tmr   <= TMR_W'(CS_GAP - 1);
            cs_no <= 1'b1;
          end
        end
        GAP: begin
          if (tmr == '0) begin
            state   <= LDAC;
            tmr     <= TMR_W'(LDAC_LEN - 1);
            ldac_no <= 1'b0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        LDAC: begin
          if (tmr == '0) begin
            state   <= IDLE;
            ldac_no <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
